// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: on-chip self-test sequencer for a single inverter cell.
// Drives the inverter input through the patterns 0 then 1, LOOPS times.
// Each pattern is held for a SETTLE-cycle wait plus one CHECK cycle.
// At the end of each CHECK cycle the inverter output is compared against
// the complement of the drive. Mismatches are counted with saturation,
// and a pass/fail verdict is registered at the end of the run.
//
// Handshake: start is a level sampled only in IDLE (no ready/ack).
// done is a one-cycle pulse marking the end of a run. pass and err_cnt
// are valid from done until the next accepted start.
module gate_bist_ctrl #(
  parameter int SETTLE = 1,
  parameter int LOOPS  = 1,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [LOOP_W-1:0]  loop_q;
  logic               pat_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [ERR_W-1:0]   err_q;

  logic               mismatch;
  logic [ERR_W-1:0]   err_d;

  // Compare the inverter output against the expected complement and form
  // the saturating error count; err_d is used for the verdict at run end.
  always_comb begin
    mismatch = (dut_y != ~pat_q);
    err_d    = err_q;
    if (mismatch && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      loop_q  <= '0;
      pat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pat_q   <= 1'b0;
            cnt_q   <= '0;
            loop_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // The counter may wrap on the exit edge; it is reloaded in CHECK.
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SETTLE - 1)) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          err_q <= err_d;
          cnt_q <= '0;
          if (!pat_q) begin
            pat_q   <= 1'b1;
            state_q <= S_SETTLE;
          end else if (loop_q != LOOP_W'(LOOPS - 1)) begin
            loop_q  <= loop_q + LOOP_W'(1);
            pat_q   <= 1'b0;
            state_q <= S_SETTLE;
          end else begin
            pass_q  <= (err_d == '0);
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // The drive keeps its last value (1) until the next run starts.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dut_a   = pat_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Testbench for gate_bist_ctrl.
// Four instances cover the parameter sets of interest. Each instance has a
// fault-injectable inverter model: good, output stuck-at-0, or buffer.
module tb_gate_bist_ctrl;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic [3:0] start_v;
  logic [3:0] a_v;
  logic [3:0] y_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [3:0] pass_v;
  logic [3:0] err_v [4];
  logic [3:0] err0, err2, err3;
  logic [1:0] err1;
  logic [1:0] mode_v [4];  // 0 good, 1 stuck-at-0, 2 buffer

  for (genvar g = 0; g < 4; g++) begin : g_inv
    assign y_v[g] = (mode_v[g] == 2'd0) ? ~a_v[g] :
                    (mode_v[g] == 2'd1) ? 1'b0 : a_v[g];
  end

  assign err_v[0] = err0;
  assign err_v[1] = {2'b00, err1};
  assign err_v[2] = err2;
  assign err_v[3] = err3;

  gate_bist_ctrl #(.SETTLE(1), .LOOPS(1), .ERR_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dut_a(a_v[0]), .dut_y(y_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err0));
  gate_bist_ctrl #(.SETTLE(1), .LOOPS(4), .ERR_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dut_a(a_v[1]), .dut_y(y_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err1));
  gate_bist_ctrl #(.SETTLE(3), .LOOPS(1), .ERR_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dut_a(a_v[2]), .dut_y(y_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_cnt(err2));
  gate_bist_ctrl #(.SETTLE(1), .LOOPS(3), .ERR_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .dut_a(a_v[3]), .dut_y(y_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_cnt(err3));

  // ---------------- scoreboard ----------------
  // Entry layout: {latency[7:0], pass, err_cnt[3:0]}
  logic [12:0] exp_q [$];
  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference parameters of each instance.
  function automatic int settle_of(input int i);
    case (i)
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int loops_of(input int i);
    case (i)
      1:       return 4;
      3:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int errmax_of(input int i);
    return (i == 1) ? 3 : 15;
  endfunction

  // ---------------- driver tasks ----------------
  // One complete run on instance i with the given fault mode. Optionally
  // re-pulses start mid-run and checks the dut_a pattern cycle by cycle.
  task automatic run(input int i, input int mode, input bit repulse, input bit seq);
    int s, l, n, lat;
    logic [12:0] e;
    bit seen;
    s = settle_of(i);
    l = loops_of(i);
    // stuck-at-0 fails only the a=0 pattern; buffer fails both patterns
    n = (mode == 0) ? 0 : (mode == 1) ? l : 2 * l;
    if (n > errmax_of(i)) n = errmax_of(i);
    lat = 2 * l * (s + 1);
    exp_q.push_back({lat[7:0], (n == 0), n[3:0]});
    mode_v[i] = mode[1:0];
    e = '0;

    @(negedge clk);
    start_v[i] = 1'b1;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
    check("accept_busy", 32'(busy_v[i]), 1);
    check("accept_err",  32'(err_v[i]),  0);
    check("accept_pass", 32'(pass_v[i]), 0);
    check("accept_a",    32'(a_v[i]),    0);

    seen = 1'b0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      if (repulse && k == 2) start_v[i] = 1'b1;
      if (repulse && k == 3) start_v[i] = 1'b0;
      @(posedge clk);
      #1;
      if (done_v[i]) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        check("done_latency", 32'(k), 32'(e[12:5]));
        check("done_err",     32'(err_v[i]), 32'(e[3:0]));
        check("done_pass",    32'(pass_v[i]), 32'(e[4]));
        check("done_busy",    32'(busy_v[i]), 1);
      end else if (seq) begin
        check("dut_a_seq", 32'(a_v[i]), 32'((k / (s + 1)) % 2));
      end
    end
    start_v[i] = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
      e = exp_q.pop_front();
    end

    @(posedge clk);
    #1;
    check("idle_done", 32'(done_v[i]), 0);
    check("idle_busy", 32'(busy_v[i]), 0);
    check("idle_pass", 32'(pass_v[i]), 32'(e[4]));
    check("idle_err",  32'(err_v[i]),  32'(e[3:0]));
    check("idle_a",    32'(a_v[i]),    1);
  endtask

  task automatic check_all_reset(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_a"},    32'(a_v[i]),    0);
      check({tag, "_busy"}, 32'(busy_v[i]), 0);
      check({tag, "_done"}, 32'(done_v[i]), 0);
      check({tag, "_pass"}, 32'(pass_v[i]), 0);
      check({tag, "_err"},  32'(err_v[i]),  0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    int k1;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start_v  = '0;
    for (int i = 0; i < 4; i++) mode_v[i] = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed runs
    run(0, 0, 1'b0, 1'b1);  // good inverter, SETTLE=1 LOOPS=1
    run(3, 1, 1'b0, 1'b1);  // stuck-at-0, LOOPS=3 -> 3 errors
    run(1, 2, 1'b0, 1'b1);  // buffer, ERR_W=2 LOOPS=4 -> saturates at 3
    run(2, 0, 1'b0, 1'b1);  // SETTLE=3, 4-cycle holds, done after 8 edges
    run(3, 2, 1'b1, 1'b1);  // re-pulse start while busy, failing run
    run(3, 0, 1'b1, 1'b0);  // new start after failing run clears verdict

    // Back-to-back: start held high gives one IDLE cycle between runs
    mode_v[0] = 2'd0;
    @(negedge clk);
    start_v[0] = 1'b1;
    seen = 1'b0;
    k1 = 0;
    for (int k = 0; k <= 50 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) begin
        seen = 1'b1;
        k1 = k;
      end
    end
    check("b2b_first_done", 32'(seen), 1);
    check("b2b_first_latency", 32'(k1), 4);
    @(posedge clk);
    #1;
    check("b2b_gap_busy", 32'(busy_v[0]), 0);
    @(posedge clk);
    #1;
    check("b2b_restart_busy", 32'(busy_v[0]), 1);
    check("b2b_restart_pass", 32'(pass_v[0]), 0);
    start_v[0] = 1'b0;
    seen = 1'b0;
    k1 = 0;
    for (int k = 1; k <= 50 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) begin
        seen = 1'b1;
        k1 = k;
      end
    end
    check("b2b_second_latency", 32'(k1), 4);
    check("b2b_second_pass", 32'(pass_v[0]), 1);
    repeat (2) @(posedge clk);

    // Reset during the second SETTLE of a buffer-fault run
    mode_v[0] = 2'd2;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_err",  32'(err_v[0]),  1);
    check("pre_reset_a",    32'(a_v[0]),    1);
    check("pre_reset_busy", 32'(busy_v[0]), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_reset("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) seen = 1'b1;
    end
    check("no_done_after_reset", 32'(seen), 0);
    run(0, 0, 1'b0, 1'b1);

    // Randomised runs across instances and fault modes
    repeat (8) begin
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
          1'($urandom_range(0, 1)), 1'b1);
    end

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
